// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: N = 1<<SHIFT clocks per bit, mid-bit sampling, valid/ready output.
// Define UART_RX_MAJORITY_EN to take each bit as a 2-of-3 vote over the three clocks ending at mid-bit.
module uart_rx_os #(
    parameter int SHIFT      = 4,
    parameter int WORD_WIDTH = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY     = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx,
    output logic [WORD_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  overrun,
    output logic                  busy
);
    localparam int N  = 1 << SHIFT;
    localparam int BW = $clog2(WORD_WIDTH);
    localparam logic [SHIFT-1:0] PH_MID    = SHIFT'(N / 2);
    localparam logic [SHIFT-1:0] PH_MID1   = SHIFT'(N / 2 + 1);
    localparam logic [SHIFT-1:0] PH_LAST   = SHIFT'(N - 1);
    localparam logic [BW-1:0]    BIT_LAST  = BW'(WORD_WIDTH - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic             PAR_ODD   = (PARITY == 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t                  state_q;
    logic                    sync1_q, sync2_q;
    logic                    rx_s;
    logic                    sample_d;
    logic                    armed_q;
    logic [SHIFT-1:0]        phase_q;
    logic [BW-1:0]           bit_q;
    logic                    stop_q;
    logic [WORD_WIDTH-1:0]   shreg_q;
    logic                    perr_q, ferr_q;
    logic [WORD_WIDTH-1:0]   dout_q;
    logic                    dout_valid_q, parity_err_q, frame_err_q, overrun_q, busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
        end
    end
    assign rx_s = sync2_q;

`ifdef UART_RX_MAJORITY_EN
    // early_q holds rx_s from the two clocks before the current one
    logic [1:0] early_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) early_q <= 2'b11;
        else        early_q <= {early_q[0], rx_s};
    end
    assign sample_d = (early_q[0] & early_q[1]) | (early_q[0] & rx_s) | (early_q[1] & rx_s);
`else
    assign sample_d = rx_s;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            armed_q      <= 1'b0;
            phase_q      <= '0;
            bit_q        <= '0;
            stop_q       <= 1'b0;
            shreg_q      <= '0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (dout_valid_q && dout_ready) dout_valid_q <= 1'b0;
            if (state_q != IDLE) phase_q <= phase_q + 1'b1;
            unique case (state_q)
                IDLE: begin
                    if (rx_s) begin
                        armed_q <= 1'b1;
                    end else if (armed_q) begin
                        state_q <= START;
                        phase_q <= '0;
                        armed_q <= 1'b0;
                        busy_q  <= 1'b1;
                        perr_q  <= 1'b0;
                        ferr_q  <= 1'b0;
                    end
                end
                START: begin
                    if (phase_q == PH_MID && sample_d) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (phase_q == PH_LAST) begin
                        state_q <= DATA;
                        bit_q   <= '0;
                    end
                end
                DATA: begin
                    if (phase_q == PH_MID) shreg_q[bit_q] <= sample_d;
                    if (phase_q == PH_LAST) begin
                        if (bit_q == BIT_LAST) begin
                            state_q <= (PARITY != 0) ? PAR : STOP;
                            stop_q  <= 1'b0;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end
                end
                PAR: begin
                    if (phase_q == PH_MID) perr_q <= ((^shreg_q) ^ sample_d) != PAR_ODD;
                    if (phase_q == PH_LAST) begin
                        state_q <= STOP;
                        stop_q  <= 1'b0;
                    end
                end
                STOP: begin
                    if (phase_q == PH_MID) begin
                        ferr_q <= ferr_q | ~sample_d;
                        // Last stop sample publishes; a held, unaccepted word wins over the new one
                        if (stop_q == LAST_STOP) begin
                            if (!dout_valid_q || dout_ready) begin
                                dout_q       <= shreg_q;
                                parity_err_q <= perr_q;
                                frame_err_q  <= ferr_q | ~sample_d;
                                dout_valid_q <= 1'b1;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                        end
                    end
                    if (phase_q == PH_MID1 && stop_q == LAST_STOP) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (phase_q == PH_LAST) begin
                        stop_q <= stop_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: an 8N1 instance and an 8E1 instance driven with directed frames.
module tb_uart_rx_os;
    localparam int N = 16;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        int         t;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       rx, dout_ready;
    logic [7:0] dout;
    logic       dout_valid, parity_err, frame_err, overrun, busy;
    logic       rx_p, ready_p;
    logic [7:0] dout_p;
    logic       valid_p, perr_p, ferr_p, ovr_p, busy_p;

    int   cyc = 0;
    int   checks = 0, errors = 0;
    int   ovr_cnt_a = 0, ovr_cnt_p = 0;
    exp_t qa[$], qp[$];
    exp_t ea, ep;

    uart_rx_os #(.SHIFT(4), .WORD_WIDTH(8), .STOP_BITS(1), .PARITY(0)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .parity_err(parity_err), .frame_err(frame_err),
        .overrun(overrun), .busy(busy)
    );

    uart_rx_os #(.SHIFT(4), .WORD_WIDTH(8), .STOP_BITS(1), .PARITY(2)) dut_p (
        .clk(clk), .rst_n(rst_n), .rx(rx_p), .dout(dout_p), .dout_valid(valid_p),
        .dout_ready(ready_p), .parity_err(perr_p), .frame_err(ferr_p),
        .overrun(ovr_p), .busy(busy_p)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: each accepted word is popped from its queue and compared
    always @(negedge clk) begin
        if (rst_n && dout_valid && dout_ready) begin
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word_a: got 0x%0h expected none", dout);
            end else begin
                ea = qa.pop_front();
                chk("dout_a", dout, ea.d);
                chk("perr_a", parity_err, ea.pe);
                chk("ferr_a", frame_err, ea.fe);
                if (ea.t >= 0) chk("latency_a", cyc, ea.t);
            end
        end
        if (rst_n && overrun) ovr_cnt_a++;
    end

    always @(negedge clk) begin
        if (rst_n && valid_p && ready_p) begin
            if (qp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word_p: got 0x%0h expected none", dout_p);
            end else begin
                ep = qp.pop_front();
                chk("dout_p", dout_p, ep.d);
                chk("perr_p", perr_p, ep.pe);
                chk("ferr_p", ferr_p, ep.fe);
                if (ep.t >= 0) chk("latency_p", cyc, ep.t);
            end
        end
        if (rst_n && ovr_p) ovr_cnt_p++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // All stimulus tasks start and end just after a rising edge
    task automatic drive(input bit sel, input logic v);
        if (sel) rx_p = v;
        else     rx   = v;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bits(input bit sel, input logic [15:0] bits, input int len, input int glitch_k);
        for (int k = 0; k < len; k++)
            for (int c = 0; c < N; c++)
                drive(sel, (k == glitch_k && c == N / 2 + 1) ? ~bits[k] : bits[k]);
    endtask

    task automatic wait_neg(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    function automatic logic [15:0] f8n1(input logic [7:0] d);
        return {6'b0, 1'b1, d, 1'b0};
    endfunction

    function automatic logic [15:0] f8p1(input logic [7:0] d, input logic p);
        return {5'b0, 1'b1, p, d, 1'b0};
    endfunction

    int         t0;
    int         ovr0;
    logic [7:0] words_a [2] = '{8'h3C, 8'h81};
    logic [7:0] par_d   [3] = '{8'h07, 8'h07, 8'hF0};
    logic       par_b   [3] = '{1'b0, 1'b1, 1'b0};
    logic       par_e   [3] = '{1'b1, 1'b0, 1'b0};
    logic [7:0] glitch_exp;

    initial begin
        rst_n = 1'b0;
        rx = 1'b1;
        rx_p = 1'b1;
        dout_ready = 1'b1;
        ready_p = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_dout", dout, 0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_perr", parity_err, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid_p", valid_p, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(4);

        // 0xA5 8N1 with exact latency and busy/valid edges
        t0 = cyc + 1;
        qa.push_back('{8'hA5, 1'b0, 1'b0, t0 + 155});
        fork
            send_bits(1'b0, f8n1(8'hA5), 10, -1);
            begin
                wait_neg(t0 + 1);   chk("busy_before_detect", busy, 0);
                wait_neg(t0 + 2);   chk("busy_rise", busy, 1);
                wait_neg(t0 + 154); chk("valid_early", dout_valid, 0);
                wait_neg(t0 + 155); chk("valid_at_pub", dout_valid, 1);
                                    chk("busy_at_pub", busy, 1);
                wait_neg(t0 + 156); chk("valid_one_cycle", dout_valid, 0);
                                    chk("busy_fall", busy, 0);
            end
        join
        idle(2 * N);

        foreach (words_a[i]) begin
            t0 = cyc + 1;
            qa.push_back('{words_a[i], 1'b0, 1'b0, t0 + 155});
            send_bits(1'b0, f8n1(words_a[i]), 10, -1);
            idle(2 * N);
        end

        // Even parity instance
        foreach (par_d[i]) begin
            t0 = cyc + 1;
            qp.push_back('{par_d[i], par_e[i], 1'b0, t0 + 171});
            send_bits(1'b1, f8p1(par_d[i], par_b[i]), 11, -1);
            idle(2 * N);
        end

        // Short low pulse: false start
        for (int i = 0; i < N / 4; i++) drive(1'b0, 1'b0);
        chk("busy_false_start_rise", busy, 1);
        drive(1'b0, 1'b1);
        idle(3 * N);
        chk("busy_false_start_fall", busy, 0);

        // Back-to-back with consumer stalled: second word overruns
        dout_ready = 1'b0;
        ovr0 = ovr_cnt_a;
        qa.push_back('{8'h11, 1'b0, 1'b0, -1});
        send_bits(1'b0, f8n1(8'h11), 10, -1);
        send_bits(1'b0, f8n1(8'h22), 10, -1);
        idle(N);
        chk("overrun_count", ovr_cnt_a - ovr0, 1);
        chk("dout_held", dout, 8'h11);
        chk("valid_held", dout_valid, 1);
        dout_ready = 1'b1;
        idle(2);
        chk("valid_after_accept", dout_valid, 0);
        chk("no_second_word", qa.size(), 0);
        idle(N);

        // Break: line low for two frame times
        t0 = cyc + 1;
        qa.push_back('{8'h00, 1'b0, 1'b1, t0 + 155});
        for (int i = 0; i < 200; i++) drive(1'b0, 1'b0);
        chk("busy_during_break", busy, 0);
        for (int i = 0; i < 120; i++) drive(1'b0, 1'b0);
        drive(1'b0, 1'b1);
        idle(4 * N);
        chk("busy_after_break", busy, 0);
        chk("break_one_word", qa.size(), 0);

        // One-clock glitch at mid-bit of data bit 3
`ifdef UART_RX_MAJORITY_EN
        glitch_exp = 8'h00;
`else
        glitch_exp = 8'h08;
`endif
        t0 = cyc + 1;
        qa.push_back('{glitch_exp, 1'b0, 1'b0, t0 + 155});
        send_bits(1'b0, f8n1(8'h00), 10, 4);
        idle(2 * N);

        chk("queue_a_empty", qa.size(), 0);
        chk("queue_p_empty", qp.size(), 0);
        chk("overrun_p_none", ovr_cnt_p, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

Oversampling UART receiver, parametrised successor to the correlator's simple serial receiver. Synchronises the asynchronous `rx` line, qualifies the start bit at mid-bit, samples data, optional parity and stop bits at bit centre, and delivers each word over a valid/ready handshake with per-word parity, framing and overrun status. It sits between the board serial pin and the correlator command/config decoder.

## Interface
- `SHIFT`, 4: log2 of clocks per bit; N = 1<<SHIFT; legal range 2..8.
- `WORD_WIDTH`, 8: data bits per word, 5..16, LSB first.
- `STOP_BITS`, 1: stop bits, 1..2.
- `PARITY`, 0: 0 none, 1 odd, 2 even (P = 1 if PARITY≠0, else 0).

- `clk`  in  1  sole clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx`  in  1  serial line, asynchronous, idle high.
- `dout`  out  WORD_WIDTH  received word.
- `dout_valid`  out  1  word available.
- `dout_ready`  in  1  consumer accepts word.
- `parity_err`  out  1  parity mismatch for `dout`; 0 when PARITY=0.
- `frame_err`  out  1  a stop bit sampled low for `dout`.
- `overrun`  out  1  one-cycle pulse: completed word dropped.
- `busy`  out  1  high in any state except IDLE.

## Operation
- Two-flop synchroniser on `rx` (both flops reset to 1); all logic uses synchronised `rx_s`.
- Counters: phase 0..N-1 (wraps per bit), bit index 0..WORD_WIDTH-1, stop index.
- States: IDLE, START, DATA, PAR, STOP.
- IDLE: `armed` set when `rx_s`=1. When armed and `rx_s`=0: go START, phase=0, clear armed.
- START: sample at phase N/2; if 1, false start, go IDLE, no output. At phase N-1 go DATA, bit index 0.
- DATA: sample at phase N/2 into bit [index]; after bit WORD_WIDTH-1 at phase N-1 go PAR (P=1) or STOP.
- PAR: sample at N/2; parity_err_int = XOR(data, sample) ≠ (PARITY==1 ? 1 : 0).
- STOP: sample each stop bit at N/2; any 0 sets frame_err_int. At the sample of the last stop bit: publish the word, go IDLE the next cycle (half-bit early, so back-to-back frames are caught).
- Publish: if `dout_valid`=0 or (`dout_valid` & `dout_ready`) same cycle: load `dout`, `parity_err`, `frame_err`, set `dout_valid`. Otherwise the new word is discarded, the old one is held, and `overrun` pulses 1 cycle.
- `dout_valid` falls on the edge where `dout_valid`&`dout_ready`, unless a publish occurs that cycle.
- Break (line low through stop): word delivered with `frame_err`=1; no new start until `rx_s` returns high (armed).
- Words with errors are still delivered; the consumer decides.

## Timing
- Reset values: `dout`=0, `dout_valid`=0, `parity_err`=0, `frame_err`=0, `overrun`=0, `busy`=0; state IDLE, armed=0, synchroniser=1.
- Reset mid-frame aborts the frame with no output; after release, the receiver re-arms only after `rx_s` is seen high.
- `rx` low before edge t0: IDLE detects at edge t0+2; START phase 0 is the next cycle.
- Sample of frame bit k (k=0 start) occurs at edge t0+3+k·N+N/2.
- `dout_valid` is visible after edge t0+3+(WORD_WIDTH+P+STOP_BITS)·N+N/2. Defaults: t0+155.
- `busy` rises after edge t0+2 and falls one cycle after the publish edge.
- Output fields are stable while `dout_valid`=1 and `dout_ready`=0.

## Configuration
- `UART_RX_MAJORITY_EN` defined: each sample is the 2-of-3 majority of `rx_s` at phases N/2-2, N/2-1 and N/2, decided at phase N/2. Latency is unchanged.
- Not defined: single sample of `rx_s` at phase N/2.

## Test plan
- Defaults, frame 0xA5, 8N1, `dout_ready`=1 -> `dout`=0xA5, `dout_valid` high 1 cycle, exactly t0+155, errors 0.
- PARITY=2, byte 0x07 sent with parity bit 0 -> `dout`=0x07, `parity_err`=1; resend with parity 1 -> `parity_err`=0.
- `rx` low pulse of N/4 clocks -> false start, `busy` returns 0, no `dout_valid`.
- Two back-to-back frames 0x11 then 0x22 with `dout_ready`=0 -> `dout`=0x11 held, `overrun` pulse at second publish; then ready -> 0x11 accepted, no 0x22.
- Line held low for 2 frames, then high -> one word 0x00 with `frame_err`=1, no further word until a new falling edge.
- With `UART_RX_MAJORITY_EN`, 1-clock glitch at phase N/2 of a data bit -> bit value correct; without the macro -> bit corrupted.
